result_collector: RTL and testbench

- Sits directly downstream of the NUM_SOLVERS pattern solvers. Gathers each solver's 4-bit encoded iteration result and assigns it the pixel coordinate that solver is working on.
- Writes each pixel to the frame buffer through a request/acknowledge port, then releases the solver to start its next pixel.
- Tracks total pixels written and flags frame completion.

---
 rtl/fractal_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/result_collector.sv | 168 ++++++++++++++++
 tb/tb_result_collector.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared constants and collector state encoding for the fractal renderer.
package fractal_pkg;

    localparam int NUM_COLUMNS   = 640;
    localparam int NUM_ROWS      = 480;
    localparam int PIXEL_WIDTH   = 4;
    localparam int FB_ADDR_WIDTH = 19;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE,
        RELEASE,
        DONE
    } collector_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
module rr_arbiter
    import fractal_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] request,
    input  logic [IDX_W-1:0] pointer,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cand = IDX_W'((32'(pointer) + i) % WIDTH);
            if (!valid && request[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects solver results, writes them to the frame buffer and releases solvers.
// Optional COLLECTOR_STALL_COUNT_EN adds a saturating write-stall counter output.
module result_collector #(
    parameter int NUM_SOLVERS = 4,
    parameter int NUM_COLUMNS = fractal_pkg::NUM_COLUMNS,
    parameter int NUM_ROWS    = fractal_pkg::NUM_ROWS,
    parameter int ADDR_WIDTH  = fractal_pkg::FB_ADDR_WIDTH
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic [fractal_pkg::PIXEL_WIDTH*NUM_SOLVERS-1:0] solver_out,
    input  logic [NUM_SOLVERS-1:0]                        solver_ready,
    input  logic [NUM_SOLVERS-1:0]                        solver_done,
    output logic [NUM_SOLVERS-1:0]                        solver_continue,
    output logic                                          wr_en,
    output logic [ADDR_WIDTH-1:0]                         wr_addr,
    output logic [fractal_pkg::PIXEL_WIDTH-1:0]           wr_data,
    input  logic                                          wr_ack,
    output logic                                          busy,
    output logic                                          frame_done
`ifdef COLLECTOR_STALL_COUNT_EN
    ,
    output logic [31:0]                                   stall_cycles
`endif
);

    import fractal_pkg::*;

    localparam int unsigned IDX_W = idx_width(NUM_SOLVERS);
    localparam int unsigned TOTAL = NUM_COLUMNS * NUM_ROWS;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);

    collector_state_t state, state_next;

    logic [IDX_W-1:0]       pointer;
    logic [IDX_W-1:0]       lane;
    logic [NUM_SOLVERS-1:0] lane_onehot;
    logic [IDX_W-1:0]       gnt_index;
    logic [NUM_SOLVERS-1:0] gnt_onehot;
    logic                   gnt_valid;
    logic [NUM_SOLVERS-1:0] pending;
    logic [NUM_SOLVERS-1:0] eligible;
    logic                   advance;
    logic [CNT_W-1:0]       pixel_count;
    logic [ADDR_WIDTH-1:0]  lane_addr [NUM_SOLVERS];

    assign advance  = (state == WRITE) && wr_ack && !start;
    assign eligible = solver_ready & pending;

    // Each lane walks its interleaved rows with adds only.
    for (genvar k = 0; k < NUM_SOLVERS; k++) begin : g_lane
        logic [9:0]            column;
        logic [9:0]            row;
        logic [ADDR_WIDTH-1:0] addr;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                column <= '0;
                row    <= '0;
                addr   <= '0;
            end else if (start) begin
                column <= '0;
                row    <= 10'(k);
                addr   <= ADDR_WIDTH'(k * NUM_COLUMNS);
            end else if (advance && lane_onehot[k]) begin
                if (column == 10'(NUM_COLUMNS - 1)) begin
                    column <= '0;
                    row    <= row + 10'(NUM_SOLVERS);
                    addr   <= addr + ROW_STEP;
                end else begin
                    column <= column + 10'd1;
                    addr   <= addr + ADDR_WIDTH'(1);
                end
            end
        end

        assign lane_addr[k] = addr;
        assign pending[k]   = (row < 10'(NUM_ROWS));
    end

    rr_arbiter #(
        .WIDTH (NUM_SOLVERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .request (eligible),
        .pointer (pointer),
        .grant   (gnt_onehot),
        .index   (gnt_index),
        .valid   (gnt_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = SCAN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                SCAN:    if (gnt_valid) state_next = WRITE;
                WRITE:   if (wr_ack) state_next = RELEASE;
                RELEASE: state_next = (pixel_count == CNT_W'(TOTAL)) ? DONE : SCAN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            solver_continue <= '0;
            pointer         <= '0;
            lane            <= '0;
            lane_onehot     <= '0;
            pixel_count     <= '0;
        end else begin
            solver_continue <= '0;
            if (start) begin
                wr_en       <= 1'b0;
                pointer     <= '0;
                pixel_count <= '0;
            end else begin
                if (state == SCAN && gnt_valid) begin
                    wr_en       <= 1'b1;
                    wr_addr     <= lane_addr[gnt_index];
                    wr_data     <= solver_out[int'(gnt_index)*PIXEL_WIDTH +: PIXEL_WIDTH];
                    lane        <= gnt_index;
                    lane_onehot <= gnt_onehot;
                end
                if (advance) begin
                    wr_en           <= 1'b0;
                    solver_continue <= lane_onehot;
                    pixel_count     <= pixel_count + CNT_W'(1);
                    pointer         <= (lane == IDX_W'(NUM_SOLVERS - 1)) ? '0 : lane + IDX_W'(1);
                end
            end
        end
    end

    assign busy       = (state == SCAN) || (state == WRITE) || (state == RELEASE);
    assign frame_done = (state == DONE);

`ifdef COLLECTOR_STALL_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (start) begin
            stall_cycles <= '0;
        end else if (state == WRITE && !wr_ack && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // A solver claiming completion while its tracker still owes rows means lost pixels.
    frame_end_check: assert property (@(posedge clock) disable iff (!reset_n)
        (state == DONE) |-> ((solver_done & pending) == '0));

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: small 2-lane 4x3 frame plus full-size wrap check.
module tb_result_collector;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        start;
    logic [7:0]  solver_out;
    logic [1:0]  solver_ready;
    logic [1:0]  solver_done;
    logic [1:0]  solver_continue;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic        frame_done;
    logic [31:0] stall_cycles;

    logic        start2;
    logic [15:0] out2;
    logic [3:0]  ready2;
    logic [3:0]  done2;
    logic [3:0]  cont2;
    logic        wr_en2;
    logic [18:0] wr_addr2;
    logic [3:0]  wr_data2;
    logic        ack2;
    logic        busy2;
    logic        frame_done2;
    logic [31:0] stall2;

    result_collector #(
        .NUM_SOLVERS (2),
        .NUM_COLUMNS (4),
        .NUM_ROWS    (3),
        .ADDR_WIDTH  (19)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .solver_out      (solver_out),
        .solver_ready    (solver_ready),
        .solver_done     (solver_done),
        .solver_continue (solver_continue),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .busy            (busy),
        .frame_done      (frame_done)
`ifdef COLLECTOR_STALL_COUNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    result_collector #(
        .NUM_SOLVERS (4),
        .NUM_COLUMNS (640),
        .NUM_ROWS    (480),
        .ADDR_WIDTH  (19)
    ) dut_full (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start2),
        .solver_out      (out2),
        .solver_ready    (ready2),
        .solver_done     (done2),
        .solver_continue (cont2),
        .wr_en           (wr_en2),
        .wr_addr         (wr_addr2),
        .wr_data         (wr_data2),
        .wr_ack          (ack2),
        .busy            (busy2),
        .frame_done      (frame_done2)
`ifdef COLLECTOR_STALL_COUNT_EN
        ,
        .stall_cycles    (stall2)
`endif
    );

`ifndef COLLECTOR_STALL_COUNT_EN
    assign stall_cycles = '0;
    assign stall2       = '0;
`endif

    logic [18:0] addr_q  [$];
    logic [3:0]  data_q  [$];
    int          lane_q  [$];
    logic [18:0] addr2_q [$];

    always @(negedge clock) begin
        if (wr_en && wr_ack) begin
            addr_q.push_back(wr_addr);
            data_q.push_back(wr_data);
        end
        if (solver_continue != 2'b00) lane_q.push_back(solver_continue[1] ? 1 : 0);
        if (wr_en2 && ack2) addr2_q.push_back(wr_addr2);
    end

    int exp_addr [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 8, 9, 10, 11};
    int exp_lane [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_queues();
        addr_q.delete();
        data_q.delete();
        lane_q.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        solver_out   = 8'h10;
        solver_ready = 2'b00;
        solver_done  = 2'b00;
        wr_ack       = 1'b0;
        start2       = 1'b0;
        out2         = 16'h0003;
        ready2       = 4'b0000;
        done2        = 4'b0000;
        ack2         = 1'b1;

        #12;
        chk("reset_wr_en",      32'(wr_en), 32'd0);
        chk("reset_wr_addr",    32'(wr_addr), 32'd0);
        chk("reset_wr_data",    32'(wr_data), 32'd0);
        chk("reset_busy",       32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_continue",   32'(solver_continue), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Full 4x3 frame, both lanes always ready, ack tied high.
        clear_queues();
        solver_ready = 2'b11;
        wr_ack       = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_frame_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 200 && !frame_done; i++) tick();
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("frame_writes", 32'(addr_q.size()), 32'd12);
        chk("frame_continues", 32'(lane_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < addr_q.size()) begin
                chk($sformatf("frame_addr%0d", i), 32'(addr_q[i]), 32'(exp_addr[i]));
                chk($sformatf("frame_data%0d", i), 32'(data_q[i]), 32'(exp_lane[i]));
            end
            if (i < lane_q.size())
                chk($sformatf("frame_lane%0d", i), 32'(lane_q[i]), 32'(exp_lane[i]));
        end

        // Write stalled five cycles by the frame buffer.
        clear_queues();
        wr_ack = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_wr_en%0d", i),   32'(wr_en), 32'd1);
            chk($sformatf("stall_addr%0d", i),    32'(wr_addr), 32'd0);
            chk($sformatf("stall_data%0d", i),    32'(wr_data), 32'd0);
            chk($sformatf("stall_cont%0d", i),    32'(solver_continue), 32'd0);
            tick();
        end
        wr_ack = 1'b1;
        tick();
        chk("ack_continue", 32'(solver_continue), 32'd1);
        chk("ack_wr_en", 32'(wr_en), 32'd0);
`ifdef COLLECTOR_STALL_COUNT_EN
        chk("stall_cycles", stall_cycles, 32'd5);
`endif
        tick();
        chk("continue_one_cycle", 32'(solver_continue), 32'd0);

        // Restart mid-frame after seven pixels.
        for (int i = 0; i < 100 && addr_q.size() < 7; i++) tick();
        chk("abort_seven_written", 32'(addr_q.size()), 32'd7);
        clear_queues();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 20 && addr_q.size() < 2; i++) tick();
        chk("restart_writes", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() >= 2) begin
            chk("restart_addr0", 32'(addr_q[0]), 32'd0);
            chk("restart_addr1", 32'(addr_q[1]), 32'd4);
            chk("restart_data1", 32'(data_q[1]), 32'd1);
        end

        // Restart while a write is pending: no release pulse.
        wr_ack = 1'b0;
        for (int i = 0; i < 10 && !wr_en; i++) tick();
        chk("pending_wr_en", 32'(wr_en), 32'd1);
        lane_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_write_wr_en", 32'(wr_en), 32'd0);
        chk("abort_write_cont", 32'(solver_continue), 32'd0);
        repeat (2) tick();
        chk("abort_no_continue", 32'(lane_q.size()), 32'd0);

        // Asynchronous reset in the middle of a write.
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        for (int i = 0; i < 10 && !wr_en; i++) tick();
        chk("prereset_addr", 32'(wr_addr), 32'd4);
        chk("prereset_data", 32'(wr_data), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_wr_en",      32'(wr_en), 32'd0);
        chk("async_wr_addr",    32'(wr_addr), 32'd0);
        chk("async_wr_data",    32'(wr_data), 32'd0);
        chk("async_busy",       32'(busy), 32'd0);
        chk("async_frame_done", 32'(frame_done), 32'd0);
        chk("async_continue",   32'(solver_continue), 32'd0);
`ifdef COLLECTOR_STALL_COUNT_EN
        chk("async_stall", stall_cycles, 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // Full-size geometry: lane 0 wraps from (row 0, col 639) to row 4.
        ready2 = 4'b0001;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 3000 && addr2_q.size() < 641; i++) tick();
        chk("full_writes", 32'(addr2_q.size() >= 641), 32'd1);
        if (addr2_q.size() >= 641) begin
            chk("full_last_col", 32'(addr2_q[639]), 32'd639);
            chk("full_wrap", 32'(addr2_q[640]), 32'd2560);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
